// File: rtl/fpu_pkg.sv
// Shared RV32F dispatch definitions: opcode/funct constants, error codes,
// FSM state encoding, op-select payload and small decode helpers.
package fpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned FREG_AW   = 5;
    localparam int unsigned NUM_FREGS = 32;

    // RV32F major opcodes and function fields
    localparam logic [6:0] OPC_FLW    = 7'b0000111;
    localparam logic [6:0] OPC_FSW    = 7'b0100111;
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [6:0] F7_FADD_S  = 7'b0000000;
    localparam logic [6:0] F7_FMUL_S  = 7'b0001000;
    localparam logic [6:0] F7_FDIV_S  = 7'b0001100;

    // Completion status reported alongside instr_done
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        FOP_ILL  = 3'd0,
        FOP_FLW  = 3'd1,
        FOP_FSW  = 3'd2,
        FOP_FADD = 3'd3,
        FOP_FMUL = 3'd4,
        FOP_FDIV = 3'd5
    } fop_e;

    // One-hot op select presented to the FPU
    typedef struct packed {
        logic flw;
        logic fsw;
        logic fadd;
        logic fmul;
        logic fdiv;
    } fpu_sel_t;

    // Classify an instruction word; the rounding-mode field is ignored
    function automatic fop_e decode_op(input logic [XLEN-1:0] iw);
        fop_e op;
        op = FOP_ILL;
        case (iw[6:0])
            OPC_FLW:   if (iw[14:12] == F3_WORD) op = FOP_FLW;
            OPC_FSW:   if (iw[14:12] == F3_WORD) op = FOP_FSW;
            OPC_OP_FP: begin
                case (iw[31:25])
                    F7_FADD_S: op = FOP_FADD;
                    F7_FMUL_S: op = FOP_FMUL;
                    F7_FDIV_S: op = FOP_FDIV;
                    default:   op = FOP_ILL;
                endcase
            end
            default:   op = FOP_ILL;
        endcase
        return op;
    endfunction

    // Sign-extended load/store offset; zero for register-register ops
    function automatic logic [XLEN-1:0] decode_imm(input logic [XLEN-1:0] iw, input fop_e op);
        logic [XLEN-1:0] imm;
        imm = '0;
        if (op == FOP_FLW) imm = {{20{iw[31]}}, iw[31:20]};
        else if (op == FOP_FSW) imm = {{20{iw[31]}}, iw[31:25], iw[11:7]};
        return imm;
    endfunction

    // The attached FPU only completes loads, stores and adds
    function automatic logic op_issuable(input fop_e op);
        return (op == FOP_FLW) || (op == FOP_FSW) || (op == FOP_FADD);
    endfunction

    function automatic fpu_sel_t op_to_sel(input fop_e op);
        fpu_sel_t sel;
        sel      = '0;
        sel.flw  = (op == FOP_FLW);
        sel.fsw  = (op == FOP_FSW);
        sel.fadd = (op == FOP_FADD);
        sel.fmul = (op == FOP_FMUL);
        sel.fdiv = (op == FOP_FDIV);
        return sel;
    endfunction

endpackage

// File: rtl/fpu_regfile.sv
// 32x32 floating-point register file.
// Ports: clk/rst_n; write port (we, waddr, wdata); two read ports captured into
// registers on rd_cap and zeroed on rd_clr (rdata1/rdata2); combinational debug
// read (dbg_addr -> dbg_data_c).
module fpu_regfile
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [FREG_AW-1:0] waddr,
    input  logic [XLEN-1:0]    wdata,
    input  logic               rd_cap,
    input  logic               rd_clr,
    input  logic [FREG_AW-1:0] raddr1,
    input  logic [FREG_AW-1:0] raddr2,
    output logic [XLEN-1:0]    rdata1,
    output logic [XLEN-1:0]    rdata2,
    input  logic [FREG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]    dbg_data_c
);

    logic [XLEN-1:0] regs_q [NUM_FREGS];

    // Storage; f0 is an ordinary writable register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_FREGS); i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Operand capture; clear takes priority so the FPU bus idles at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (rd_clr) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (rd_cap) begin
            rdata1 <= regs_q[raddr1];
            rdata2 <= regs_q[raddr2];
        end
    end

    assign dbg_data_c = regs_q[dbg_addr];

endmodule

// File: rtl/fpu_dispatch.sv
// RV32F dispatcher in front of the FPU execution unit: decodes FLW/FSW/FADD.S
// (FMUL.S/FDIV.S recognised but rejected), reads operands from the FP register
// file, issues one op at a time, waits for completion with a watchdog and
// writes the result back.
// Ports: instr_valid/instr_word/int_rs1_data/instr_ready from the core;
// instr_done/instr_err status back; fpu_enabled strobe, one-hot fpu_instr_*
// select and fpu_reg_rs1/fpu_freg_rs1/fpu_freg_rs2/fpu_imm operands to the FPU;
// fpu_completed/fpu_result from the FPU; dbg_freg_addr/dbg_freg_data debug read.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr_word,
    input  logic [31:0] int_rs1_data,
    output logic        instr_ready,
    output logic        instr_done,
    output logic [1:0]  instr_err,
    output logic        fpu_enabled,
    output logic        fpu_instr_flw,
    output logic        fpu_instr_fsw,
    output logic        fpu_instr_fadd,
    output logic        fpu_instr_fdiv,
    output logic        fpu_instr_fmul,
    output logic [31:0] fpu_reg_rs1,
    output logic [31:0] fpu_freg_rs1,
    output logic [31:0] fpu_freg_rs2,
    output logic [31:0] fpu_imm,
    input  logic        fpu_completed,
    input  logic [31:0] fpu_result,
    input  logic [4:0]  dbg_freg_addr,
    output logic [31:0] dbg_freg_data
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    fop_e               op_q, op_d;
    logic [FREG_AW-1:0] rd_q, rd_d;
    fpu_sel_t           sel_q, sel_d;
    logic               ready_d, done_d, enable_d;
    logic [1:0]         err_d;
    logic [XLEN-1:0]    base_d, imm_d;

    fop_e               dec_op_c;
    logic [FREG_AW-1:0] raddr1_c;
    logic               rf_cap_c, rf_clr_c, rf_we_c;

    assign dec_op_c = decode_op(instr_word);
    // FSW store data sits in the rs2 field but travels on fpu_freg_rs1
    assign raddr1_c = (dec_op_c == FOP_FSW) ? instr_word[24:20] : instr_word[19:15];

    fpu_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (rf_we_c),
        .waddr      (rd_q),
        .wdata      (fpu_result),
        .rd_cap     (rf_cap_c),
        .rd_clr     (rf_clr_c),
        .raddr1     (raddr1_c),
        .raddr2     (instr_word[24:20]),
        .rdata1     (fpu_freg_rs1),
        .rdata2     (fpu_freg_rs2),
        .dbg_addr   (dbg_freg_addr),
        .dbg_data_c (dbg_freg_data)
    );

    // Next state and next registered-output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sel_d    = sel_q;
        ready_d  = instr_ready;
        done_d   = 1'b0;
        err_d    = ERR_OK;
        enable_d = 1'b0;
        base_d   = fpu_reg_rs1;
        imm_d    = fpu_imm;
        rf_cap_c = 1'b0;
        rf_clr_c = 1'b0;
        rf_we_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d    = dec_op_c;
                    rd_d    = instr_word[11:7];
                    ready_d = 1'b0;
                    if (op_issuable(dec_op_c)) begin
                        state_d  = ST_ISSUE;
                        enable_d = 1'b1;
                        sel_d    = op_to_sel(dec_op_c);
                        base_d   = int_rs1_data;
                        imm_d    = decode_imm(instr_word, dec_op_c);
                        rf_cap_c = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        err_d   = ERR_ILLEGAL;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // Completion on the expiry cycle still counts as success
                if (fpu_completed || (cnt_q == CNT_LAST)) begin
                    state_d  = ST_RESP;
                    done_d   = 1'b1;
                    err_d    = fpu_completed ? ERR_OK : ERR_TIMEOUT;
                    rf_we_c  = fpu_completed && ((op_q == FOP_FLW) || (op_q == FOP_FADD));
                    sel_d    = '0;
                    base_d   = '0;
                    imm_d    = '0;
                    rf_clr_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                sel_d   = '0;
                base_d  = '0;
                imm_d   = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= FOP_ILL;
            rd_q        <= '0;
            sel_q       <= '0;
            instr_ready <= 1'b1;
            instr_done  <= 1'b0;
            instr_err   <= ERR_OK;
            fpu_enabled <= 1'b0;
            fpu_reg_rs1 <= '0;
            fpu_imm     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            sel_q       <= sel_d;
            instr_ready <= ready_d;
            instr_done  <= done_d;
            instr_err   <= err_d;
            fpu_enabled <= enable_d;
            fpu_reg_rs1 <= base_d;
            fpu_imm     <= imm_d;
        end
    end

    assign fpu_instr_flw  = sel_q.flw;
    assign fpu_instr_fsw  = sel_q.fsw;
    assign fpu_instr_fadd = sel_q.fadd;
    assign fpu_instr_fmul = sel_q.fmul;
    assign fpu_instr_fdiv = sel_q.fdiv;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch: a bench-side FPU model answers each
// fpu_enabled strobe after a chosen latency; results are compared against
// hand-computed values.
module tb_fpu_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic [31:0] int_rs1_data;
    logic        instr_ready;
    logic        instr_done;
    logic [1:0]  instr_err;
    logic        fpu_enabled;
    logic        fpu_instr_flw, fpu_instr_fsw, fpu_instr_fadd, fpu_instr_fdiv, fpu_instr_fmul;
    logic [31:0] fpu_reg_rs1, fpu_freg_rs1, fpu_freg_rs2, fpu_imm;
    logic        fpu_completed;
    logic [31:0] fpu_result;
    logic [4:0]  dbg_freg_addr;
    logic [31:0] dbg_freg_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Snapshot of FPU-side outputs taken in the ISSUE cycle
    logic [4:0]  snap_sel;
    logic [31:0] snap_base, snap_op1, snap_op2, snap_imm;
    int          hold_bad;

    fpu_dispatch #(.TIMEOUT_CYCLES(1024), .CNT_W(11)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instr_word     (instr_word),
        .int_rs1_data   (int_rs1_data),
        .instr_ready    (instr_ready),
        .instr_done     (instr_done),
        .instr_err      (instr_err),
        .fpu_enabled    (fpu_enabled),
        .fpu_instr_flw  (fpu_instr_flw),
        .fpu_instr_fsw  (fpu_instr_fsw),
        .fpu_instr_fadd (fpu_instr_fadd),
        .fpu_instr_fdiv (fpu_instr_fdiv),
        .fpu_instr_fmul (fpu_instr_fmul),
        .fpu_reg_rs1    (fpu_reg_rs1),
        .fpu_freg_rs1   (fpu_freg_rs1),
        .fpu_freg_rs2   (fpu_freg_rs2),
        .fpu_imm        (fpu_imm),
        .fpu_completed  (fpu_completed),
        .fpu_result     (fpu_result),
        .dbg_freg_addr  (dbg_freg_addr),
        .dbg_freg_data  (dbg_freg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] sel_vec();
        return {fpu_instr_flw, fpu_instr_fsw, fpu_instr_fadd, fpu_instr_fmul, fpu_instr_fdiv};
    endfunction

    function automatic logic [31:0] enc_flw(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000111};
    endfunction

    function automatic logic [31:0] enc_fsw(input int rs2, input int rs1, input int imm);
        logic [11:0] i12;
        i12 = 12'(imm);
        return {i12[11:5], 5'(rs2), 5'(rs1), 3'b010, i12[4:0], 7'b0100111};
    endfunction

    function automatic logic [31:0] enc_opfp(input logic [6:0] f7, input int rd, input int rs1,
                                             input int rs2, input logic [2:0] rm);
        return {f7, 5'(rs2), 5'(rs1), rm, 5'(rd), 7'b1010011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
        dbg_freg_addr = 5'(idx);
        #1;
        chk(tag, dbg_freg_data, exp);
    endtask

    // Present one instruction at a negedge and run it to instr_done.
    // lat < 0: FPU never completes. Cycles are counted from the accept edge.
    task automatic run_op(input logic [31:0] iw, input logic [31:0] base, input int lat,
                          input logic [31:0] res, output int cycles, output logic [1:0] err,
                          output int en_cnt);
        int since_en;
        instr_word   = iw;
        int_rs1_data = base;
        instr_valid  = 1'b1;
        fpu_result   = res;
        @(negedge clk);
        instr_valid  = 1'b0;
        instr_word   = 32'h0;
        int_rs1_data = 32'h0;
        cycles   = -1;
        err      = 2'b11;
        en_cnt   = 0;
        since_en = -1;
        hold_bad = 0;
        for (int cyc = 1; cyc <= 1100; cyc++) begin
            if (fpu_enabled) begin
                en_cnt++;
                since_en  = 0;
                snap_sel  = sel_vec();
                snap_base = fpu_reg_rs1;
                snap_op1  = fpu_freg_rs1;
                snap_op2  = fpu_freg_rs2;
                snap_imm  = fpu_imm;
            end else if (since_en >= 0) begin
                since_en++;
            end
            if (instr_done) begin
                cycles = cyc;
                err    = instr_err;
                break;
            end
            if (since_en >= 1 && (sel_vec() !== snap_sel || fpu_reg_rs1 !== snap_base ||
                fpu_freg_rs1 !== snap_op1 || fpu_freg_rs2 !== snap_op2 || fpu_imm !== snap_imm))
                hold_bad++;
            // Registered FPU: completes lat cycles after sampling the strobe
            fpu_completed = (lat >= 0) && (since_en == lat + 1);
            @(negedge clk);
        end
        fpu_completed = 1'b0;
        @(negedge clk);
        chk("done_is_pulse", {31'h0, instr_done}, 32'h0);
    endtask

    initial begin
        int          cyc;
        logic [1:0]  err;
        int          en;
        int          done_seen;

        rst_n         = 1'b0;
        instr_valid   = 1'b0;
        instr_word    = 32'h0;
        int_rs1_data  = 32'h0;
        fpu_completed = 1'b0;
        fpu_result    = 32'h0;
        dbg_freg_addr = 5'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, instr_ready}, 32'h1);
        chk("rst_done", {31'h0, instr_done}, 32'h0);
        chk("rst_err", {30'h0, instr_err}, 32'h0);
        chk("rst_enable", {31'h0, fpu_enabled}, 32'h0);
        chk("rst_sel", {27'h0, sel_vec()}, 32'h0);
        chk("rst_imm", fpu_imm, 32'h0);
        chk_reg("rst_f0", 0, 32'h0);
        chk_reg("rst_f31", 31, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // FLW f3, 8(x1)
        run_op(enc_flw(3, 1, 8), 32'h100, 2, 32'h3F800000, cyc, err, en);
        chk("flw_latency", 32'(cyc), 32'd5);
        chk("flw_err", {30'h0, err}, 32'h0);
        chk("flw_enable_pulses", 32'(en), 32'd1);
        chk("flw_imm", snap_imm, 32'h8);
        chk("flw_base", snap_base, 32'h100);
        chk("flw_sel", {27'h0, snap_sel}, 32'h10);
        chk("flw_hold", 32'(hold_bad), 32'd0);
        chk("flw_ready_after", {31'h0, instr_ready}, 32'h1);
        chk("flw_imm_idle", fpu_imm, 32'h0);
        chk_reg("flw_f3", 3, 32'h3F800000);

        // Load the FADD operands
        run_op(enc_flw(1, 0, 0), 32'h0, 1, 32'h3F800000, cyc, err, en);
        run_op(enc_flw(2, 0, 4), 32'h0, 1, 32'h40000000, cyc, err, en);
        chk_reg("ld_f1", 1, 32'h3F800000);
        chk_reg("ld_f2", 2, 32'h40000000);

        // FADD.S f5, f1, f2 with dynamic rounding mode; 5-cycle FPU
        run_op(enc_opfp(7'b0000000, 5, 1, 2, 3'b111), 32'h0, 5, 32'h40400000, cyc, err, en);
        chk("fadd_latency", 32'(cyc), 32'd8);
        chk("fadd_err", {30'h0, err}, 32'h0);
        chk("fadd_enable_pulses", 32'(en), 32'd1);
        chk("fadd_op1", snap_op1, 32'h3F800000);
        chk("fadd_op2", snap_op2, 32'h40000000);
        chk("fadd_sel", {27'h0, snap_sel}, 32'h04);
        chk("fadd_imm", snap_imm, 32'h0);
        chk("fadd_hold", 32'(hold_bad), 32'd0);
        chk_reg("fadd_f5", 5, 32'h40400000);

        // FSW f5, -4(x2): store only, rd field (f28) must stay untouched
        run_op(enc_fsw(5, 2, -4), 32'h200, 3, 32'hDEADBEEF, cyc, err, en);
        chk("fsw_latency", 32'(cyc), 32'd6);
        chk("fsw_err", {30'h0, err}, 32'h0);
        chk("fsw_imm", snap_imm, 32'hFFFFFFFC);
        chk("fsw_base", snap_base, 32'h200);
        chk("fsw_data", snap_op1, 32'h40400000);
        chk("fsw_sel", {27'h0, snap_sel}, 32'h08);
        chk_reg("fsw_f28", 28, 32'h0);
        chk_reg("fsw_f5", 5, 32'h40400000);
        chk_reg("fsw_f3", 3, 32'h3F800000);

        // FMUL.S f7, f1, f2 is decoded but never issued
        run_op(enc_opfp(7'b0001000, 7, 1, 2, 3'b000), 32'h0, 1, 32'h11111111, cyc, err, en);
        chk("fmul_latency", 32'(cyc), 32'd1);
        chk("fmul_err", {30'h0, err}, 32'h1);
        chk("fmul_enable_pulses", 32'(en), 32'd0);
        chk_reg("fmul_f7", 7, 32'h0);

        // Integer ADD x1, x2, x3 (opcode 0x33) is illegal
        run_op(32'h003100B3, 32'h0, 1, 32'h22222222, cyc, err, en);
        chk("illegal_latency", 32'(cyc), 32'd1);
        chk("illegal_err", {30'h0, err}, 32'h1);
        chk("illegal_enable_pulses", 32'(en), 32'd0);

        // FADD.S f6 with the FPU never completing: 1024 WAIT cycles then timeout
        run_op(enc_opfp(7'b0000000, 6, 1, 2, 3'b000), 32'h0, -1, 32'h33333333, cyc, err, en);
        chk("timeout_latency", 32'(cyc), 32'd1026);
        chk("timeout_err", {30'h0, err}, 32'h2);
        chk_reg("timeout_f6", 6, 32'h0);

        // Same op, completion lands on the expiry cycle: success with writeback
        run_op(enc_opfp(7'b0000000, 6, 1, 2, 3'b000), 32'h0, 1023, 32'h12345678, cyc, err, en);
        chk("expiry_latency", 32'(cyc), 32'd1026);
        chk("expiry_err", {30'h0, err}, 32'h0);
        chk_reg("expiry_f6", 6, 32'h12345678);

        // Reset in the middle of WAIT, then a stray completion in IDLE
        instr_word  = enc_opfp(7'b0000000, 8, 1, 2, 3'b000);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'h0, instr_ready}, 32'h1);
        chk("midrst_sel", {27'h0, sel_vec()}, 32'h0);
        chk("midrst_base", fpu_reg_rs1, 32'h0);
        chk("midrst_op1", fpu_freg_rs1, 32'h0);
        @(negedge clk);
        rst_n         = 1'b1;
        fpu_result    = 32'hCAFEF00D;
        fpu_completed = 1'b1;
        done_seen     = 0;
        @(negedge clk);
        fpu_completed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (instr_done || fpu_enabled) done_seen++;
            @(negedge clk);
        end
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        chk("midrst_ready_after", {31'h0, instr_ready}, 32'h1);
        chk_reg("midrst_f8", 8, 32'h0);
        chk_reg("midrst_f5", 5, 32'h0);
        chk_reg("midrst_f6", 6, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_dispatch.md
Name: fpu_dispatch

Overview:
- Sits directly upstream of the FPU execution unit.
- Accepts RV32F instruction words from the integer core and decodes FLW/FSW/FADD.S/FMUL.S/FDIV.S.
- Owns the 32x32 FP register file: reads operands, drives the FPU one operation at a time, waits for its completion pulse and writes the result back to rd.
- Reports done/illegal/timeout status to the core.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles in WAIT before aborting with timeout error.
- CNT_W, 11: width of watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  core presents instruction
- instr_word  in  32  RV32 instruction word
- int_rs1_data  in  32  integer rs1 value (FLW/FSW base address)
- instr_ready  out  1  dispatcher idle; accepts instr_valid
- instr_done  out  1  one-cycle completion pulse
- instr_err  out  2  valid with instr_done: 0 ok, 1 illegal/unsupported, 2 timeout
- fpu_enabled  out  1  one-cycle start strobe to FPU
- fpu_instr_flw, fpu_instr_fsw, fpu_instr_fadd, fpu_instr_fdiv, fpu_instr_fmul  out  1 each  one-hot op select
- fpu_reg_rs1  out  32  integer base to FPU
- fpu_freg_rs1  out  32  FP operand 1 (also FSW store data)
- fpu_freg_rs2  out  32  FP operand 2
- fpu_imm  out  32  sign-extended offset
- fpu_completed  in  1  FPU completion pulse
- fpu_result  in  32  FPU result, valid with fpu_completed
- dbg_freg_addr  in  5  debug read address
- dbg_freg_data  out  32  combinational read of FP register dbg_freg_addr

Behaviour:
- Reset: state IDLE; all outputs 0 except instr_ready=1; all 32 FP registers 0; watchdog counter 0. Reset mid-operation aborts immediately, with no writeback. f0 is an ordinary writable register.
- Decode:
  - FLW: opcode 0000111, funct3 010; imm = sext(instr[31:20]).
  - FSW: opcode 0100111, funct3 010; imm = sext({instr[31:25], instr[11:7]}).
  - OP-FP: opcode 1010011, funct7 0000000 FADD.S, 0001000 FMUL.S, 0001100 FDIV.S; rm field ignored.
  - Anything else is illegal.
  - FMUL.S/FDIV.S are decoded but the current FPU does not complete them; they are reported as err=1 and never issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: instr_ready=1. On instr_valid: latch decoded op, rd, imm, int_rs1_data, freg[rs1] and freg[rs2] into the operand registers.
    - Legal op -> ISSUE.
    - Illegal or unsupported op -> RESP with err=1.
  - ISSUE (exactly 1 cycle): fpu_enabled=1 -> WAIT; watchdog cleared.
  - WAIT: counter increments each cycle.
    - On fpu_completed: FLW/FADD write fpu_result into freg[rd] at that edge; FSW writes nothing. -> RESP with err=0.
    - Else when counter reaches TIMEOUT_CYCLES-1 -> RESP with err=2, no writeback.
    - fpu_completed on the expiry cycle wins: treated as success.
  - RESP (1 cycle): instr_done=1, instr_err valid -> IDLE.
- fpu_enabled is high only in ISSUE. This is mandatory because the FPU re-triggers if enabled is high while it is idle.
- Op-select, operand and imm outputs are held constant from ISSUE through WAIT; they return to 0 in IDLE.
- instr_valid is ignored while instr_ready=0; no queueing.
- fpu_completed outside WAIT is ignored.
- Operands are read at accept time. A writeback to freg[rd] is visible to the next accepted instruction (no hazard possible, since issue is strictly serial).
- Latency: accept edge -> ISSUE -> WAIT(N) -> RESP. instr_done asserts N+3 cycles after the accept edge, where N is the FPU's cycles-to-completed. Illegal ops: instr_done 1 cycle after accept.

Decomposition:
- Shared package fpu_pkg: RV32F opcode/funct3/funct7 constants, err codes (ERR_OK/ERR_ILLEGAL/ERR_TIMEOUT), FSM state encoding.
- One sub-module, fpu_regfile: 32x32, async-reset, one write port, two registered-capture read ports plus one combinational debug port.

Test Plan:
- FLW f3, 8(x1), int_rs1_data=0x100; FPU model completes with result 0x3F800000 -> fpu_imm=8, fpu_reg_rs1=0x100, one fpu_enabled pulse, instr_done with err=0, dbg read f3=0x3F800000.
- f1=0x3F800000, f2=0x40000000, FADD.S f5,f1,f2; model returns 0x40400000 after 5 cycles -> instr_done exactly 8 cycles after accept, f5=0x40400000, fpu_enabled high exactly 1 cycle.
- FSW f5, -4(x2), int_rs1_data=0x200 -> fpu_imm=0xFFFFFFFC, fpu_freg_rs1=f5 value, no register changes, err=0.
- FMUL.S and opcode 0x33 -> instr_done 1 cycle after accept, err=1, fpu_enabled never asserted.
- FADD with the model never completing -> instr_done after TIMEOUT_CYCLES in WAIT, err=2, f[rd] unchanged. Repeat with fpu_completed on the expiry cycle -> err=0 and writeback.
- Assert rst_n low mid-WAIT, then issue a spurious fpu_completed after release -> all outputs 0, instr_ready=1, registers 0, no writeback, no instr_done.
